alu_seq: RTL and testbench

Parametrised, handshaked successor to the combinational 64-bit ALU. It keeps the AND/OR/ADD/SUB encoding and the zero flag, and adds SLT, NOR, overflow and error flags. It also adds iterative multi-cycle MUL/DIVU/REMU. It sits between the decode/operand stage and writeback, using a valid/ready handshake on both sides.

---
 rtl/alu_seq.sv | 213 +++++++++++++++++++++
 tb/tb_alu_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with single-cycle logic/arithmetic ops and
// iterative multi-cycle MUL / DIVU / REMU (one bit per clock).
//
// Handshake: an operation is accepted on a rising edge where
// in_valid && in_ready, and a result is consumed on a rising edge where
// out_valid && out_ready. in_ready is high only in IDLE (and never
// during or in the cycle of reset release); out_valid is high only in
// DONE. Only one operation is in flight at a time.
module alu_seq #(
  parameter int WIDTH     = 64,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_result,
  output logic             zero,
  output logic             overflow,
  output logic             err
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;

  // Counter must be able to hold the value WIDTH (finalise cycle).
  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // Gates in_ready so it stays low until the first edge after reset release.
  logic ready_en_q;

  logic accept;
  logic op_is_md;

  // Single-cycle datapath outputs
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] dif;
  logic [WIDTH-1:0] sc_res;
  logic             sc_ovf;
  logic             sc_err;

  // Iterative datapath registers:
  //   MUL : op_a = shifted multiplicand, op_b = shifted multiplier, acc = product
  //   DIV : op_a = dividend shifting out / quotient shifting in,
  //         op_b = divisor, acc = partial remainder
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic [WIDTH-1:0] acc_q;
  logic [3:0]       md_op_q;
  logic [CW-1:0]    cnt_q;

  // Restoring-divide step signals
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic             take;
  logic [WIDTH-1:0] md_res;

  // Registered outputs
  logic [WIDTH-1:0] res_q;
  logic             zero_q;
  logic             ovf_q;
  logic             err_q;

  assign in_ready   = ready_en_q && (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign accept     = in_valid && in_ready;
  assign op_is_md   = MULDIV_EN && ((ALU_operation == OP_MUL) ||
                                    (ALU_operation == OP_DIVU) ||
                                    (ALU_operation == OP_REMU));

  assign ALU_result = res_q;
  assign zero       = zero_q;
  assign overflow   = ovf_q;
  assign err        = err_q;

  // Single-cycle opcode evaluation from the live operands.
  always_comb begin
    sum    = A + B;
    dif    = A - B;
    sc_res = '0;
    sc_ovf = 1'b0;
    sc_err = 1'b0;
    case (ALU_operation)
      OP_AND: sc_res = A & B;
      OP_OR:  sc_res = A | B;
      OP_NOR: sc_res = ~(A | B);
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = dif;
        sc_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (dif[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      default: begin
        sc_res = '0;
        sc_err = 1'b1;
      end
    endcase
  end

  // One restoring-divide step: shift next dividend bit into the remainder,
  // trial-subtract the divisor, keep it if no borrow. A zero divisor never
  // borrows, which naturally yields quotient all-ones and remainder A.
  always_comb begin
    rem_sh   = {acc_q, op_a_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, op_b_q};
    take     = ~rem_diff[WIDTH];
    md_res   = (md_op_q == OP_DIVU) ? op_a_q : acc_q;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = op_is_md ? CALC : DONE;
      CALC: if (cnt_q == CNT_LAST) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture single-cycle results at accept, iterate MUL/DIV in
  // CALC, and register the iterative result in the finalise cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      acc_q   <= '0;
      md_op_q <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (op_is_md) begin
              op_a_q  <= A;
              op_b_q  <= B;
              acc_q   <= '0;
              md_op_q <= ALU_operation;
              cnt_q   <= '0;
            end else begin
              res_q  <= sc_res;
              zero_q <= (sc_res == '0);
              ovf_q  <= sc_ovf;
              err_q  <= sc_err;
            end
          end
        end
        CALC: begin
          if (cnt_q != CNT_LAST) begin
            if (md_op_q == OP_MUL) begin
              if (op_b_q[0]) acc_q <= acc_q + op_a_q;
              op_a_q <= op_a_q << 1;
              op_b_q <= op_b_q >> 1;
            end else begin
              acc_q  <= take ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
              op_a_q <= {op_a_q[WIDTH-2:0], take};
            end
            cnt_q <= cnt_q + CW'(1);
          end else begin
            res_q  <= md_res;
            zero_q <= (md_res == '0);
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
          end
        end
        default: begin
          // DONE: hold outputs until the result handshake.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (WIDTH=64), plus a MULDIV_EN=0 instance.
module tb_alu_seq;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;
  localparam logic [3:0] OP_BAD  = 4'b1111;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT signals
  logic        in_valid;
  logic        in_ready;
  logic [63:0] A;
  logic [63:0] B;
  logic [3:0]  ALU_operation;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] ALU_result;
  logic        zero;
  logic        overflow;
  logic        err;

  // MULDIV_EN=0 instance signals
  logic        n_in_valid;
  logic        n_in_ready;
  logic [3:0]  n_op;
  logic        n_out_valid;
  logic        n_out_ready;
  logic [63:0] n_result;
  logic        n_zero;
  logic        n_overflow;
  logic        n_err;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq #(.WIDTH(64), .MULDIV_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALU_operation(ALU_operation),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALU_result(ALU_result), .zero(zero), .overflow(overflow), .err(err)
  );

  alu_seq #(.WIDTH(64), .MULDIV_EN(1'b0)) u_dut_nomd (
    .clk(clk), .rst_n(rst_n),
    .in_valid(n_in_valid), .in_ready(n_in_ready),
    .A(A), .B(B), .ALU_operation(n_op),
    .out_valid(n_out_valid), .out_ready(n_out_ready),
    .ALU_result(n_result), .zero(n_zero), .overflow(n_overflow), .err(n_err)
  );

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // exp_lat = rising edges after the accept edge until out_valid is seen
  // (0 for single-cycle ops, WIDTH+1 for MUL/DIVU/REMU).
  // hold = cycles with out_ready low once the result is visible.
  // pulse_at = busy-cycle index at which a spurious in_valid is driven (-1 none).
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_res, input logic exp_zero,
                        input logic exp_ovf, input logic exp_err,
                        input int exp_lat, input int hold, input int pulse_at);
    int lat;
    logic [63:0] held;
    @(negedge clk);
    check({tag, " in_ready idle"}, 64'(in_ready), 64'd1);
    A = a; B = b; ALU_operation = op; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    in_valid = 1'b0;
    A = ~a; B = ~b;               // operands must have been sampled at accept
    while (!out_valid && lat < 200) begin
      check({tag, " in_ready busy"}, 64'(in_ready), 64'd0);
      if (lat == pulse_at) begin
        in_valid = 1'b1; A = 64'd5; B = 64'd3; ALU_operation = OP_ADD;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, ALU_result, exp_res);
    check({tag, " zero"}, 64'(zero), 64'(exp_zero));
    check({tag, " overflow"}, 64'(overflow), 64'(exp_ovf));
    check({tag, " err"}, 64'(err), 64'(exp_err));
    held = ALU_result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, " hold out_valid"}, 64'(out_valid), 64'd1);
      check({tag, " hold result"}, ALU_result, held);
      check({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, " out_valid drop"}, 64'(out_valid), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int stale;
    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; ALU_operation = '0; out_ready = 1'b1;
    n_in_valid = 1'b0; n_op = '0; n_out_ready = 1'b1;

    // reset values
    #2;
    check("rst in_ready", 64'(in_ready), 64'd0);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst result", ALU_result, 64'd0);
    check("rst zero", 64'(zero), 64'd0);
    check("rst overflow", 64'(overflow), 64'd0);
    check("rst err", 64'(err), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release in_ready before edge", 64'(in_ready), 64'd0);

    // basic ops: 45 = 0x2D, 67 = 0x43; 0x2D & 0x43 = 0x01, | = 0x6F
    run_op("and", OP_AND, 64'd45, 64'd67, 64'd1,   1'b0, 1'b0, 1'b0, 0, 0, -1);
    run_op("or",  OP_OR,  64'd45, 64'd67, 64'd111, 1'b0, 1'b0, 1'b0, 0, 0, -1);
    run_op("add", OP_ADD, 64'd45, 64'd67, 64'd112, 1'b0, 1'b0, 1'b0, 0, 0, -1);
    run_op("sub", OP_SUB, 64'd45, 64'd67, 64'hFFFF_FFFF_FFFF_FFEA, 1'b0, 1'b0, 1'b0, 0, 0, -1);
    run_op("nor", OP_NOR, 64'd45, 64'd67, 64'hFFFF_FFFF_FFFF_FF90, 1'b0, 1'b0, 1'b0, 0, 0, -1);

    // zero and overflow boundaries
    run_op("sub zero", OP_SUB, 64'd33, 64'd33, 64'd0, 1'b1, 1'b0, 1'b0, 0, 0, -1);
    run_op("add ovf", OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
           64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 0, 0, -1);
    run_op("sub ovf", OP_SUB, 64'h8000_0000_0000_0000, 64'd1,
           64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 0, 0, -1);
    run_op("slt lt", OP_SLT, ONES, 64'd1, 64'd1, 1'b0, 1'b0, 1'b0, 0, 0, -1);
    run_op("slt ge", OP_SLT, 64'd1, ONES, 64'd0, 1'b1, 1'b0, 1'b0, 0, 0, -1);

    // iterative ops: result 65 edges after accept
    run_op("mul", OP_MUL, 64'd45, 64'd67, 64'd3015, 1'b0, 1'b0, 1'b0, 65, 0, 10);
    run_op("mul wrap", OP_MUL, ONES, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 65, 0, -1);
    run_op("divu", OP_DIVU, 64'd67, 64'd45, 64'd1, 1'b0, 1'b0, 1'b0, 65, 0, -1);
    run_op("remu", OP_REMU, 64'd67, 64'd45, 64'd22, 1'b0, 1'b0, 1'b0, 65, 0, -1);
    run_op("divu by0", OP_DIVU, 64'd67, 64'd0, ONES, 1'b0, 1'b0, 1'b0, 65, 0, -1);
    run_op("remu by0", OP_REMU, 64'd67, 64'd0, 64'd67, 1'b0, 1'b0, 1'b0, 65, 0, -1);
    run_op("divu 1000/7", OP_DIVU, 64'd1000, 64'd7, 64'd142, 1'b0, 1'b0, 1'b0, 65, 0, -1);
    run_op("remu exact", OP_REMU, 64'd91, 64'd7, 64'd0, 1'b1, 1'b0, 1'b0, 65, 0, -1);

    // invalid opcode
    run_op("invalid", OP_BAD, 64'd45, 64'd67, 64'd0, 1'b1, 1'b0, 1'b1, 0, 0, -1);

    // backpressure: result held for 5 cycles
    run_op("hold add", OP_ADD, 64'd45, 64'd67, 64'd112, 1'b0, 1'b0, 1'b0, 0, 5, -1);

    // MULDIV_EN=0: MUL is an invalid opcode
    @(negedge clk);
    check("nomd in_ready", 64'(n_in_ready), 64'd1);
    A = 64'd45; B = 64'd67; n_op = OP_MUL; n_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_in_valid = 1'b0;
    check("nomd mul out_valid", 64'(n_out_valid), 64'd1);
    check("nomd mul result", n_result, 64'd0);
    check("nomd mul zero", 64'(n_zero), 64'd1);
    check("nomd mul err", 64'(n_err), 64'd1);
    check("nomd mul overflow", 64'(n_overflow), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("nomd back idle", 64'(n_in_ready), 64'd1);

    // reset in the middle of a DIVU
    @(negedge clk);
    A = 64'd1000; B = 64'd7; ALU_operation = OP_DIVU; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst in_ready", 64'(in_ready), 64'd0);
    check("midrst result", ALU_result, 64'd0);
    check("midrst zero", 64'(zero), 64'd0);
    @(negedge clk);
    check("midrst in_ready held", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    check("midrst release before edge", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("midrst in_ready after edge", 64'(in_ready), 64'd1);
    stale = 0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("midrst no stale result", 64'(stale), 64'd0);

    // recovery after reset
    run_op("remu after rst", OP_REMU, 64'd1000, 64'd7, 64'd6, 1'b0, 1'b0, 1'b0, 65, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
